// File: rtl/dht_poll_ctrl.sv
// Poll scheduler and frame checker for the DHT11 single-wire reader.
// Starts reads periodically, validates frames, retries on failure and holds the last good sample.
module dht_poll_ctrl #(
    parameter int unsigned POLL_PERIOD = 200000000,
    parameter int unsigned RETRY_GAP   = 100000000,
    parameter int unsigned TIMEOUT     = 5000000,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned CNT_W       = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        force_read,
    output logic        rd_start,
    input  logic [39:0] rd_data,
    input  logic        rd_ready,
    input  logic        rd_error,
    output logic [7:0]  hum_int,
    output logic [7:0]  hum_dec,
    output logic [7:0]  temp_int,
    output logic [7:0]  temp_dec,
    output logic        reading_valid,
    output logic        new_sample,
    output logic        read_failed,
    output logic        timeout_seen,
    output logic [7:0]  fail_cnt,
    output logic        busy
);

    localparam int unsigned RTY_W = 4;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] h_int;
        logic [7:0] h_dec;
        logic [7:0] t_int;
        logic [7:0] t_dec;
        logic [7:0] csum;
    } frame_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [RTY_W-1:0]   rty, rty_d;
    frame_t             frame_q, frame_d;
    logic [7:0]         hum_int_d, hum_dec_d, temp_int_d, temp_dec_d, fail_cnt_d;
    logic               valid_d, new_sample_d, read_failed_d, timeout_d;
    logic               rd_start_d, busy_d, fail_c;
    logic [7:0]         sum_c;

    assign sum_c = frame_q.h_int + frame_q.h_dec + frame_q.t_int + frame_q.t_dec;

    // Next-state, counter and output decisions; failures are resolved in the same cycle
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        rty_d         = rty;
        frame_d       = frame_q;
        hum_int_d     = hum_int;
        hum_dec_d     = hum_dec;
        temp_int_d    = temp_int;
        temp_dec_d    = temp_dec;
        valid_d       = reading_valid;
        new_sample_d  = 1'b0;
        read_failed_d = read_failed;
        timeout_d     = timeout_seen;
        fail_cnt_d    = fail_cnt;
        fail_c        = 1'b0;

        case (state)
            S_WAIT: begin
                if (enable) begin
                    if (force_read || cnt == '0) state_d = S_START;
                    else                         cnt_d   = cnt - CNT_W'(1);
                end
            end
            S_START: begin
                cnt_d   = CNT_W'(TIMEOUT - 1);
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (rd_ready) begin
                    frame_d = rd_data;
                    state_d = S_CHECK;
                end else if (cnt == '0) begin
                    timeout_d = 1'b1;
                    fail_c    = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (!rd_error && sum_c == frame_q.csum) begin
                    hum_int_d     = frame_q.h_int;
                    hum_dec_d     = frame_q.h_dec;
                    temp_int_d    = frame_q.t_int;
                    temp_dec_d    = frame_q.t_dec;
                    new_sample_d  = 1'b1;
                    valid_d       = 1'b1;
                    read_failed_d = 1'b0;
                    rty_d         = '0;
                    cnt_d         = CNT_W'(POLL_PERIOD - 1);
                    state_d       = S_WAIT;
                end else begin
                    fail_c = 1'b1;
                end
            end
            default: state_d = S_WAIT;
        endcase

        if (fail_c) begin
            if (fail_cnt != 8'hFF) fail_cnt_d = fail_cnt + 8'd1;
            if (rty < RTY_W'(MAX_RETRIES)) begin
                rty_d = rty + RTY_W'(1);
                cnt_d = CNT_W'(RETRY_GAP - 1);
            end else begin
                read_failed_d = 1'b1;
                rty_d         = '0;
                cnt_d         = CNT_W'(POLL_PERIOD - 1);
            end
            state_d = S_WAIT;
        end

        rd_start_d = (state_d == S_START);
        busy_d     = (state_d != S_WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_WAIT;
            cnt           <= CNT_W'(POLL_PERIOD - 1);
            rty           <= '0;
            frame_q       <= '0;
            hum_int       <= '0;
            hum_dec       <= '0;
            temp_int      <= '0;
            temp_dec      <= '0;
            reading_valid <= 1'b0;
            new_sample    <= 1'b0;
            read_failed   <= 1'b0;
            timeout_seen  <= 1'b0;
            fail_cnt      <= '0;
            rd_start      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            rty           <= rty_d;
            frame_q       <= frame_d;
            hum_int       <= hum_int_d;
            hum_dec       <= hum_dec_d;
            temp_int      <= temp_int_d;
            temp_dec      <= temp_dec_d;
            reading_valid <= valid_d;
            new_sample    <= new_sample_d;
            read_failed   <= read_failed_d;
            timeout_seen  <= timeout_d;
            fail_cnt      <= fail_cnt_d;
            rd_start      <= rd_start_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_dht_poll_ctrl.sv
// Directed bench for dht_poll_ctrl: table of reader frames plus hand-written timing corner cases.
module tb_dht_poll_ctrl;

    localparam int unsigned POLL = 100;
    localparam int unsigned GAP  = 20;
    localparam int unsigned TMO  = 500;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, force_read, rd_start, rd_ready, rd_error;
    logic [39:0] rd_data;
    logic [7:0]  hum_int, hum_dec, temp_int, temp_dec, fail_cnt;
    logic        reading_valid, new_sample, read_failed, timeout_seen, busy;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    dht_poll_ctrl #(
        .POLL_PERIOD(POLL), .RETRY_GAP(GAP), .TIMEOUT(TMO), .MAX_RETRIES(2), .CNT_W(28)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .force_read(force_read),
        .rd_start(rd_start), .rd_data(rd_data), .rd_ready(rd_ready), .rd_error(rd_error),
        .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
        .reading_valid(reading_valid), .new_sample(new_sample), .read_failed(read_failed),
        .timeout_seen(timeout_seen), .fail_cnt(fail_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [39:0] frame;
        logic        err;
        logic        exp_new;
        logic [7:0]  hi, hd, ti, td;
        logic        valid, failed;
        logic [7:0]  fcnt;
        int          gap;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until rd_start is seen; at = -1 if the bound expires
    task automatic wait_start(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            step();
            if (rd_start) at = cyc;
        end
    endtask

    // Present a frame while in S_BUSY, then rd_error the following cycle
    task automatic respond(input logic [39:0] frame, input logic err);
        rd_ready = 1'b1;
        rd_data  = frame;
        step();
        rd_ready = 1'b0;
        rd_data  = 40'h0;
        rd_error = err;
        step();
        rd_error = 1'b0;
    endtask

    initial begin
        int s, at, exp_at, w, n, nstart;
        logic [7:0] fc;

        vecs[0] = '{40'h2300190040, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'd1, GAP};
        vecs[1] = '{40'h3200160048, 1'b0, 1'b1, 8'h32, 8'h00, 8'h16, 8'h00, 1'b1, 1'b0, 8'd1, POLL};
        vecs[2] = '{40'h3200160049, 1'b0, 1'b0, 8'h32, 8'h00, 8'h16, 8'h00, 1'b1, 1'b0, 8'd2, GAP};
        vecs[3] = '{40'h3200160048, 1'b1, 1'b0, 8'h32, 8'h00, 8'h16, 8'h00, 1'b1, 1'b0, 8'd3, GAP};
        vecs[4] = '{40'h0102030406, 1'b1, 1'b0, 8'h32, 8'h00, 8'h16, 8'h00, 1'b1, 1'b1, 8'd4, POLL};
        vecs[5] = '{40'h2D0517034C, 1'b0, 1'b1, 8'h2D, 8'h05, 8'h17, 8'h03, 1'b1, 1'b0, 8'd4, POLL};
        vecs[6] = '{40'hFF01809010, 1'b0, 1'b1, 8'hFF, 8'h01, 8'h80, 8'h90, 1'b1, 1'b0, 8'd4, POLL};

        rst = 1'b0; enable = 1'b1; force_read = 1'b0;
        rd_ready = 1'b0; rd_error = 1'b0; rd_data = 40'h0;
        step(); step();
        chk("rst_rd_start", 64'(rd_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bytes", 64'({hum_int, hum_dec, temp_int, temp_dec}), 64'd0);
        chk("rst_flags", 64'({reading_valid, new_sample, read_failed, timeout_seen}), 64'd0);
        chk("rst_fail_cnt", 64'(fail_cnt), 64'd0);

        rst = 1'b1;
        exp_at = cyc + int'(POLL);

        // Frame table: each entry answers one start pulse
        for (int i = 0; i < 7; i++) begin
            wait_start(exp_at - cyc + 10, s);
            chk($sformatf("v%0d_start_time", i), 64'(s), 64'(exp_at));
            step();
            chk($sformatf("v%0d_start_width", i), 64'(rd_start), 64'd0);
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            respond(vecs[i].frame, vecs[i].err);
            chk($sformatf("v%0d_new_sample", i), 64'(new_sample), 64'(vecs[i].exp_new));
            chk($sformatf("v%0d_bytes", i), 64'({hum_int, hum_dec, temp_int, temp_dec}),
                64'({vecs[i].hi, vecs[i].hd, vecs[i].ti, vecs[i].td}));
            chk($sformatf("v%0d_valid", i), 64'(reading_valid), 64'(vecs[i].valid));
            chk($sformatf("v%0d_read_failed", i), 64'(read_failed), 64'(vecs[i].failed));
            chk($sformatf("v%0d_fail_cnt", i), 64'(fail_cnt), 64'(vecs[i].fcnt));
            chk($sformatf("v%0d_busy_after", i), 64'(busy), 64'd0);
            chk($sformatf("v%0d_timeout_seen", i), 64'(timeout_seen), 64'd0);
            exp_at = cyc + vecs[i].gap;
            step();
            chk($sformatf("v%0d_new_sample_width", i), 64'(new_sample), 64'd0);
        end

        // rd_ready in the very cycle the timeout would fire
        wait_start(exp_at - cyc + 10, s);
        chk("same_start_time", 64'(s), 64'(exp_at));
        for (int k = 0; k < int'(TMO); k++) step();
        chk("same_busy_at_limit", 64'(busy), 64'd1);
        respond(40'h1A001C0036, 1'b0);
        chk("same_new_sample", 64'(new_sample), 64'd1);
        chk("same_timeout_seen", 64'(timeout_seen), 64'd0);
        chk("same_bytes", 64'({hum_int, temp_int}), 64'h1A1C);
        chk("same_fail_cnt", 64'(fail_cnt), 64'd4);

        // force_read in S_WAIT at counter 60, then in S_BUSY (ignored)
        for (int k = 0; k < 39; k++) step();
        force_read = 1'b1;
        step();
        force_read = 1'b0;
        chk("force_start", 64'(rd_start), 64'd1);
        step();
        force_read = 1'b1;
        step();
        force_read = 1'b0;
        nstart = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (rd_start) nstart++;
        end
        chk("force_busy_no_start", 64'(nstart), 64'd0);
        respond(40'h2D0517034C, 1'b0);
        chk("force_new_sample", 64'(new_sample), 64'd1);

        // enable low freezes the interval; force_read is ignored meanwhile
        w = cyc;
        enable = 1'b0;
        for (int k = 0; k < 30; k++) begin
            force_read = (k == 10);
            step();
        end
        force_read = 1'b0;
        enable = 1'b1;
        exp_at = w + int'(POLL) + 30;

        // Three unanswered attempts: timeouts, retries, then read_failed
        fc = 8'd4;
        for (int a = 0; a < 3; a++) begin
            wait_start(exp_at - cyc + 10, s);
            chk($sformatf("to%0d_start_time", a), 64'(s), 64'(exp_at));
            n = 0;
            while (busy && n < 600) begin
                step();
                n++;
            end
            fc = fc + 8'd1;
            chk($sformatf("to%0d_latency", a), 64'(n), 64'(TMO + 1));
            chk($sformatf("to%0d_timeout_seen", a), 64'(timeout_seen), 64'd1);
            chk($sformatf("to%0d_fail_cnt", a), 64'(fail_cnt), 64'(fc));
            chk($sformatf("to%0d_read_failed", a), 64'(read_failed), (a == 2) ? 64'd1 : 64'd0);
            chk($sformatf("to%0d_bytes_held", a), 64'({hum_int, hum_dec}), 64'h2D05);
            exp_at = cyc + ((a == 2) ? int'(POLL) : int'(GAP));
        end
        wait_start(exp_at - cyc + 10, s);
        chk("recover_start_time", 64'(s), 64'(exp_at));
        step();
        respond(40'h3200160048, 1'b0);
        chk("recover_read_failed", 64'(read_failed), 64'd0);
        chk("recover_new_sample", 64'(new_sample), 64'd1);
        chk("recover_timeout_sticky", 64'(timeout_seen), 64'd1);
        exp_at = cyc + int'(POLL);

        // Reset while the start pulse is high
        wait_start(exp_at - cyc + 10, s);
        chk("mid_start_time", 64'(s), 64'(exp_at));
        rst = 1'b0;
        #1;
        chk("mid_rd_start", 64'(rd_start), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_bytes", 64'({hum_int, hum_dec, temp_int, temp_dec}), 64'd0);
        chk("mid_flags", 64'({reading_valid, new_sample, read_failed, timeout_seen}), 64'd0);
        chk("mid_fail_cnt", 64'(fail_cnt), 64'd0);
        step(); step(); step();
        rst = 1'b1;
        exp_at = cyc + int'(POLL);
        wait_start(int'(POLL) + 10, at);
        chk("post_rst_start_time", 64'(at), 64'(exp_at));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
